ps2_scancode_decoder: RTL

- Consumes bytes from the PS/2 keyboard receiver FIFO (data/ready/nextdata_n handshake) and assembles scan-code-set-2 sequences (E0/F0 prefixes) into key events.
- Tracks the currently held key, suppresses typematic repeats in the press counter, and maps base make codes to ASCII.
- Feeds the display/control logic in the NPC top level.

---
 rtl/ps2_scancode_decoder.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code-set-2 decoder: pops bytes from the receiver FIFO, folds E0/F0 prefixes
// into key events, tracks the held key, counts non-repeat presses and maps makes to ASCII.
module ps2_scancode_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_ready,
  input  logic             in_overflow,
  output logic             nextdata_n,
  output logic             evt_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic             key_repeat,
  output logic [7:0]       key_ascii,
  output logic             held,
  output logic [CNT_W-1:0] press_count,
  output logic             err_overflow
);

  typedef enum logic [1:0] {StIdle, StPop, StSettle} state_e;

  state_e           state_q, state_d;
  logic [7:0]       byte_q, byte_d;
  logic             ext_q, ext_d, brk_q, brk_d;
  logic             held_q, held_d, held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic             evt_q, evt_d;
  logic [7:0]       code_q, code_d, ascii_q, ascii_d;
  logic             kext_q, kext_d, down_q, down_d, rep_q, rep_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             held_match;

  function automatic logic [7:0] to_ascii(input logic [7:0] c);
    case (c)
      8'h1C: to_ascii = 8'h41;  8'h32: to_ascii = 8'h42;  8'h21: to_ascii = 8'h43;
      8'h23: to_ascii = 8'h44;  8'h24: to_ascii = 8'h45;  8'h2B: to_ascii = 8'h46;
      8'h34: to_ascii = 8'h47;  8'h33: to_ascii = 8'h48;  8'h43: to_ascii = 8'h49;
      8'h3B: to_ascii = 8'h4A;  8'h42: to_ascii = 8'h4B;  8'h4B: to_ascii = 8'h4C;
      8'h3A: to_ascii = 8'h4D;  8'h31: to_ascii = 8'h4E;  8'h44: to_ascii = 8'h4F;
      8'h4D: to_ascii = 8'h50;  8'h15: to_ascii = 8'h51;  8'h2D: to_ascii = 8'h52;
      8'h1B: to_ascii = 8'h53;  8'h2C: to_ascii = 8'h54;  8'h3C: to_ascii = 8'h55;
      8'h2A: to_ascii = 8'h56;  8'h1D: to_ascii = 8'h57;  8'h22: to_ascii = 8'h58;
      8'h35: to_ascii = 8'h59;  8'h1A: to_ascii = 8'h5A;
      8'h45: to_ascii = 8'h30;  8'h16: to_ascii = 8'h31;  8'h1E: to_ascii = 8'h32;
      8'h26: to_ascii = 8'h33;  8'h25: to_ascii = 8'h34;  8'h2E: to_ascii = 8'h35;
      8'h36: to_ascii = 8'h36;  8'h3D: to_ascii = 8'h37;  8'h3E: to_ascii = 8'h38;
      8'h46: to_ascii = 8'h39;
      8'h29: to_ascii = 8'h20;  8'h5A: to_ascii = 8'h0D;
      default: to_ascii = 8'h00;
    endcase
  endfunction

  assign held_match = held_q && (held_ext_q == ext_q) && (held_code_q == byte_q);

  always_comb begin
    state_d     = state_q;
    byte_d      = byte_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    held_d      = held_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    evt_d       = 1'b0;
    code_d      = code_q;
    ascii_d     = ascii_q;
    kext_d      = kext_q;
    down_d      = down_q;
    rep_d       = rep_q;
    cnt_d       = cnt_q;
    err_d       = err_q | in_overflow;
    unique case (state_q)
      StIdle: begin
        if (in_ready) begin
          byte_d  = in_data;
          state_d = StPop;
        end
      end
      StPop: begin
        state_d = StSettle;
        if (byte_q == 8'hE0) begin
          ext_d = 1'b1;
        end else if (byte_q == 8'hF0) begin
          brk_d = 1'b1;
        end else if (byte_q == 8'h00 || byte_q == 8'hFF) begin
          ext_d = 1'b0;
          brk_d = 1'b0;
        end else begin
          evt_d   = 1'b1;
          code_d  = byte_q;
          kext_d  = ext_q;
          down_d  = ~brk_q;
          ascii_d = ext_q ? 8'h00 : to_ascii(byte_q);
          ext_d   = 1'b0;
          brk_d   = 1'b0;
          rep_d   = 1'b0;
          if (!brk_q) begin
            // Typematic repeat: same key still held, so it is not a new press.
            if (held_match) begin
              rep_d = 1'b1;
            end else begin
              cnt_d       = cnt_q + CNT_W'(1);
              held_d      = 1'b1;
              held_ext_d  = ext_q;
              held_code_d = byte_q;
            end
          end else if (held_match) begin
            held_d = 1'b0;
          end
        end
      end
      StSettle: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_q      <= 8'h00;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      held_q      <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      evt_q       <= 1'b0;
      code_q      <= 8'h00;
      ascii_q     <= 8'h00;
      kext_q      <= 1'b0;
      down_q      <= 1'b0;
      rep_q       <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_q      <= byte_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      held_q      <= held_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      evt_q       <= evt_d;
      code_q      <= code_d;
      ascii_q     <= ascii_d;
      kext_q      <= kext_d;
      down_q      <= down_d;
      rep_q       <= rep_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign nextdata_n   = (state_q != StPop);
  assign evt_valid    = evt_q;
  assign key_code     = code_q;
  assign key_ext      = kext_q;
  assign key_down     = down_q;
  assign key_repeat   = rep_q;
  assign key_ascii    = ascii_q;
  assign held         = held_q;
  assign press_count  = cnt_q;
  assign err_overflow = err_q;

endmodule
